// File: rtl/msg_pkg.sv
// Shared character codes, message geometry and writer states for the HEX message path.
// The display decoder and the scroller import this package alongside the writer.
package msg_pkg;
  localparam int MSG_LEN = 6;
  localparam int CW      = 2;
  localparam int PW      = 3;

  typedef logic [CW-1:0]         char_t;
  typedef logic [MSG_LEN*CW-1:0] msg_t;
  typedef logic [PW-1:0]         ptr_t;

  localparam char_t CH_D     = 2'b00;
  localparam char_t CH_E     = 2'b01;
  localparam char_t CH_L     = 2'b10;
  localparam char_t CH_BLANK = 2'b11;

  localparam msg_t MSG_BLANK = '1;
  localparam ptr_t PTR_MAX   = PW'(MSG_LEN);

  typedef enum logic [1:0] {IDLE, ENTRY, COMMITTED} state_t;

  // Slot 0 is the leftmost digit and sits in the most significant bits.
  function automatic msg_t put_char(msg_t m, ptr_t slot, char_t c);
    msg_t r;
    r = m;
    r[(MSG_LEN-1-int'(slot))*CW +: CW] = c;
    return r;
  endfunction

  function automatic msg_t blank_from(msg_t m, ptr_t ptr);
    msg_t r;
    r = m;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (i >= int'(ptr)) r[(MSG_LEN-1-i)*CW +: CW] = CH_BLANK;
    end
    return r;
  endfunction
endpackage

// File: rtl/msg_entry_writer_if.sv
// Switch/button inputs and committed-message outputs of the message writer.
// The slave side is the writer; the master side is whatever drives the keys.
interface msg_entry_writer_if;
  import msg_pkg::*;

  char_t char_in;
  logic  wr_key_n;
  logic  commit_key_n;
  msg_t  msg;
  logic  msg_valid;
  ptr_t  wr_ptr;
  logic  full;
  logic  overflow;

  modport slave (
    input  char_in, wr_key_n, commit_key_n,
    output msg, msg_valid, wr_ptr, full, overflow
  );

  modport master (
    output char_in, wr_key_n, commit_key_n,
    input  msg, msg_valid, wr_ptr, full, overflow
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter; one-cycle pulse on an accepted press.
// Press accepted DEBOUNCE_CYCLES+2 cycles after the raw level first samples low.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNTW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: rtl/msg_entry_writer.sv
// Builds a 6-character message from debounced write presses and publishes it on commit.
// The committed register only changes on a commit, so readers never see a partial message.
module msg_entry_writer
  import msg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                CLOCK_50,
  input logic                clr,
  msg_entry_writer_if.slave  bus
);
  logic   wr_pulse;
  logic   commit_pulse;

  state_t state_q, state_nxt;
  msg_t   ent_q, ent_nxt;
  ptr_t   ptr_q, ptr_nxt;
  logic   ovf_q, ovf_nxt;
  msg_t   msg_q, msg_nxt;
  logic   vld_q, vld_nxt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_key (
    .clk   (CLOCK_50),
    .rst   (clr),
    .key_n (bus.wr_key_n),
    .press (wr_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_key (
    .clk   (CLOCK_50),
    .rst   (clr),
    .key_n (bus.commit_key_n),
    .press (commit_pulse)
  );

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      state_q <= IDLE;
      ent_q   <= MSG_BLANK;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      msg_q   <= MSG_BLANK;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ent_q   <= ent_nxt;
      ptr_q   <= ptr_nxt;
      ovf_q   <= ovf_nxt;
      msg_q   <= msg_nxt;
      vld_q   <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    ent_nxt   = ent_q;
    ptr_nxt   = ptr_q;
    ovf_nxt   = ovf_q;
    msg_nxt   = msg_q;
    vld_nxt   = vld_q;

    if (wr_pulse) begin
      unique case (state_q)
        IDLE, COMMITTED: begin
          ent_nxt   = put_char(MSG_BLANK, '0, bus.char_in);
          ptr_nxt   = PW'(1);
          ovf_nxt   = 1'b0;
          state_nxt = ENTRY;
        end
        ENTRY: begin
          if (ptr_q == PTR_MAX) begin
            ovf_nxt = 1'b1;
          end else begin
            ent_nxt = put_char(ent_q, ptr_q, bus.char_in);
            ptr_nxt = ptr_q + PW'(1);
          end
        end
        default: ;
      endcase
    end

    // Commit looks at the post-write buffer so a same-cycle write is included.
    if (commit_pulse && state_nxt == ENTRY) begin
      msg_nxt   = blank_from(ent_nxt, ptr_nxt);
      vld_nxt   = 1'b1;
      state_nxt = COMMITTED;
    end
  end

  assign bus.msg       = msg_q;
  assign bus.msg_valid = vld_q;
  assign bus.wr_ptr    = ptr_q;
  assign bus.full      = (ptr_q == PTR_MAX);
  assign bus.overflow  = ovf_q;
endmodule
